// File: rtl/ex_stage.sv
// Execute stage of the RV32 pipeline: single-cycle ALU, 32-cycle shift-add MUL,
// ex_mem pipeline registers, and a back-pressure stall to decode.
module ex_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic            clk,
  input  logic            res_n,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_ex0,
  input  logic [XLEN-1:0] id_ex1,
  input  logic [XLEN-1:0] id_ex_store,
  input  logic [4:0]      id_ex_rd,
  input  logic [7:0]      id_ex_control,
  output logic            ex_stall,
  output logic [XLEN-1:0] ex_mem_result,
  output logic [XLEN-1:0] ex_mem_store,
  output logic [4:0]      ex_mem_rd,
  output logic            ex_mem_write,
  output logic            ex_mem_read,
  output logic            ex_mem_regwrite,
  output logic            ex_mem_valid
);

  localparam int unsigned SH_W  = $clog2(XLEN);
  localparam int unsigned CNT_W = $clog2(MUL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_SLL   = 4'd2;
  localparam logic [3:0] OP_SLT   = 4'd3;
  localparam logic [3:0] OP_SLTU  = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_OR    = 4'd8;
  localparam logic [3:0] OP_AND   = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_PASSB = 4'd11;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]   mul_store_q, mul_store_d;
  logic [4:0]        mul_rd_q, mul_rd_d;
  logic              mul_wr_q, mul_wr_d;
  logic              mul_rdm_q, mul_rdm_d;
  logic              mul_rw_q, mul_rw_d;

  logic [XLEN-1:0]   result_q, result_d;
  logic [XLEN-1:0]   store_q, store_d;
  logic [4:0]        rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              rdm_q, rdm_d;
  logic              rw_q, rw_d;
  logic              valid_q, valid_d;

  logic [3:0]        op;
  logic [SH_W-1:0]   sh;
  logic              rw_eff;
  logic [XLEN-1:0]   alu_res;
  logic [XLEN-1:0]   acc_sum;
  logic              stall_c;
  logic              ctrl_unused;

  assign op          = id_ex_control[3:0];
  assign sh          = id_ex1[SH_W-1:0];
  assign rw_eff      = id_ex_control[6] & (id_ex_rd != 5'd0);
  assign ctrl_unused = id_ex_control[7];

  // Single-cycle ALU; MUL and undefined opcodes yield zero here.
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:   alu_res = id_ex0 + id_ex1;
      OP_SUB:   alu_res = id_ex0 - id_ex1;
      OP_SLL:   alu_res = id_ex0 << sh;
      OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(id_ex0) < $signed(id_ex1)};
      OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, id_ex0 < id_ex1};
      OP_XOR:   alu_res = id_ex0 ^ id_ex1;
      OP_SRL:   alu_res = id_ex0 >> sh;
      OP_SRA:   alu_res = XLEN'($signed(id_ex0) >>> sh);
      OP_OR:    alu_res = id_ex0 | id_ex1;
      OP_AND:   alu_res = id_ex0 & id_ex1;
      OP_PASSB: alu_res = id_ex1;
      default:  alu_res = '0;
    endcase
  end

  // Next-state: bubble by default; result/store/rd hold unless overwritten.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    mul_store_d = mul_store_q;
    mul_rd_d    = mul_rd_q;
    mul_wr_d    = mul_wr_q;
    mul_rdm_d   = mul_rdm_q;
    mul_rw_d    = mul_rw_q;
    result_d    = result_q;
    store_d     = store_q;
    rd_d        = rd_q;
    wr_d        = 1'b0;
    rdm_d       = 1'b0;
    rw_d        = 1'b0;
    valid_d     = 1'b0;
    stall_c     = 1'b0;
    acc_sum     = acc_q + (mplier_q[0] ? mcand_q : '0);
    case (state_q)
      S_IDLE: begin
        if (id_valid) begin
          if (op == OP_MUL) begin
            stall_c     = 1'b1;
            mcand_d     = id_ex0;
            mplier_d    = id_ex1;
            acc_d       = '0;
            cnt_d       = '0;
            mul_store_d = id_ex_store;
            mul_rd_d    = id_ex_rd;
            mul_wr_d    = id_ex_control[4];
            mul_rdm_d   = id_ex_control[5];
            mul_rw_d    = rw_eff;
            state_d     = S_BUSY;
          end else begin
            result_d = alu_res;
            store_d  = id_ex_store;
            rd_d     = id_ex_rd;
            wr_d     = id_ex_control[4];
            rdm_d    = id_ex_control[5];
            rw_d     = rw_eff;
            valid_d  = 1'b1;
          end
        end
      end
      S_BUSY: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          result_d = acc_sum;
          store_d  = mul_store_q;
          rd_d     = mul_rd_q;
          wr_d     = mul_wr_q;
          rdm_d    = mul_rdm_q;
          rw_d     = mul_rw_q;
          valid_d  = 1'b1;
          state_d  = S_IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      mul_store_q <= '0;
      mul_rd_q    <= '0;
      mul_wr_q    <= 1'b0;
      mul_rdm_q   <= 1'b0;
      mul_rw_q    <= 1'b0;
      result_q    <= '0;
      store_q     <= '0;
      rd_q        <= '0;
      wr_q        <= 1'b0;
      rdm_q       <= 1'b0;
      rw_q        <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      mul_store_q <= mul_store_d;
      mul_rd_q    <= mul_rd_d;
      mul_wr_q    <= mul_wr_d;
      mul_rdm_q   <= mul_rdm_d;
      mul_rw_q    <= mul_rw_d;
      result_q    <= result_d;
      store_q     <= store_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      rdm_q       <= rdm_d;
      rw_q        <= rw_d;
      valid_q     <= valid_d;
    end
  end

  // Stall is masked during reset so a held MUL on the inputs cannot assert it.
  assign ex_stall        = res_n & stall_c;
  assign ex_mem_result   = result_q;
  assign ex_mem_store    = store_q;
  assign ex_mem_rd       = rd_q;
  assign ex_mem_write    = wr_q;
  assign ex_mem_read     = rdm_q;
  assign ex_mem_regwrite = rw_q;
  assign ex_mem_valid    = valid_q;

endmodule
